time_set_ctrl: RTL and testbench

//   Button front end for the alarm clock. Debounces three raw buttons and runs an edit FSM.

---
 rtl/time_set_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button front end for the alarm clock.
// Synchronises and debounces the mode/inc/set buttons, generates auto-repeat
// on inc while editing, and runs the edit FSM that seeds, edits and loads the
// clock time and the alarm time. Edit-state flags let the display blink the
// field under edit.
module time_set_ctrl #(
    parameter int unsigned DEBOUNCE_TICKS = 2,
    parameter int unsigned REPEAT_TICKS   = 5,
    parameter int unsigned TIMEOUT_TICKS  = 300,
    parameter int unsigned LOAD_HOLD      = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_set,
    input  logic [1:0] cur_H1,
    input  logic [3:0] cur_H0,
    input  logic [3:0] cur_M1,
    input  logic [3:0] cur_M0,
    output logic [1:0] H_in1,
    output logic [3:0] H_in0,
    output logic [3:0] M_in1,
    output logic [3:0] M_in0,
    output logic       LD_time,
    output logic       LD_alarm,
    output logic       AL_ON,
    output logic [1:0] edit_sel,
    output logic       edit_alarm
);

    localparam int unsigned B_MODE = 0;
    localparam int unsigned B_INC  = 1;
    localparam int unsigned B_SET  = 2;

    localparam int unsigned DB_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int unsigned RP_W = $clog2(REPEAT_TICKS + 1);
    localparam int unsigned TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int unsigned LD_W = $clog2(LOAD_HOLD + 1);

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_TICKS - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [LD_W-1:0] LD_LAST = LD_W'(LOAD_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T_HOUR,
        S_T_MIN,
        S_A_HOUR,
        S_A_MIN,
        S_LOAD_T,
        S_LOAD_A
    } state_t;

    logic [2:0]            raw;
    logic [2:0]            sync1_q, sync2_q;
    logic [2:0]            deb_q, deb_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [2:0]            press_q, press_d;

    logic [RP_W-1:0]       rep_cnt_q, rep_cnt_d;
    logic                  rep_q, rep_d;
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
    logic [LD_W-1:0]       ld_cnt_q, ld_cnt_d;

    state_t                state_q, state_d;
    logic [5:0]            edit_h_q, edit_h_d;
    logic [7:0]            edit_m_q, edit_m_d;
    logic [5:0]            alm_h_q, alm_h_d;
    logic [7:0]            alm_m_q, alm_m_d;
    logic                  al_on_q, al_on_d;

    logic                  in_edit, is_alarm, is_hour;
    logic                  set_ev, mode_ev, inc_ev, any_ev, to_expire;

    assign raw = {btn_set, btn_inc, btn_mode};

    assign in_edit  = state_q inside {S_T_HOUR, S_T_MIN, S_A_HOUR, S_A_MIN};
    assign is_alarm = state_q inside {S_A_HOUR, S_A_MIN};
    assign is_hour  = state_q inside {S_T_HOUR, S_A_HOUR};

    assign set_ev    = press_q[B_SET];
    assign mode_ev   = press_q[B_MODE];
    assign inc_ev    = press_q[B_INC] | rep_q;
    assign any_ev    = set_ev | mode_ev | inc_ev;
    assign to_expire = (to_cnt_q == TO_LAST);

    // BCD hour step; anything outside 00..22 (including 23) wraps/clamps to 00
    function automatic logic [5:0] hour_inc(input logic [5:0] h);
        logic [1:0] h1;
        logic [3:0] h0;
        h1 = h[5:4];
        h0 = h[3:0];
        if (h1 > 2'd2 || h0 > 4'd9 || (h1 == 2'd2 && h0 >= 4'd3)) begin
            return '0;
        end else if (h0 == 4'd9) begin
            return {h1 + 2'd1, 4'd0};
        end else begin
            return {h1, h0 + 4'd1};
        end
    endfunction

    // BCD minute step; 59 and any out-of-range value go to 00, no hour carry
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        logic [3:0] m1;
        logic [3:0] m0;
        m1 = m[7:4];
        m0 = m[3:0];
        if (m1 > 4'd5 || m0 > 4'd9) begin
            return '0;
        end else if (m0 == 4'd9) begin
            return (m1 == 4'd5) ? 8'd0 : {m1 + 4'd1, 4'd0};
        end else begin
            return {m1, m0 + 4'd1};
        end
    endfunction

    // Two-flop synchronisers for the asynchronous raw buttons
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level after DEBOUNCE_TICKS consecutive differing samples
    always_comb begin
        deb_d    = deb_q;
        db_cnt_d = db_cnt_q;
        press_d  = '0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                deb_d[i]    = sync2_q[i];
                press_d[i]  = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Auto-repeat for inc: one pulse per REPEAT_TICKS cycles of held level while editing
    always_comb begin
        rep_cnt_d = '0;
        rep_d     = 1'b0;
        if (deb_q[B_INC] && in_edit) begin
            if (rep_cnt_q == RP_LAST) begin
                rep_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + 1'b1;
            end
        end
    end

    // Inactivity counter, cleared outside edit states and on any button event
    always_comb begin
        to_cnt_d = '0;
        if (in_edit && !any_ev) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // Edit FSM next state, edit/shadow registers, alarm enable and load-hold count
    always_comb begin
        state_d  = state_q;
        edit_h_d = edit_h_q;
        edit_m_d = edit_m_q;
        alm_h_d  = alm_h_q;
        alm_m_d  = alm_m_q;
        al_on_d  = al_on_q;
        ld_cnt_d = '0;
        case (state_q)
            S_IDLE: begin
                if (set_ev) begin
                    al_on_d = ~al_on_q;
                end else if (mode_ev) begin
                    state_d  = S_T_HOUR;
                    edit_h_d = {cur_H1, cur_H0};
                    edit_m_d = {cur_M1, cur_M0};
                end
            end
            S_T_HOUR, S_T_MIN, S_A_HOUR, S_A_MIN: begin
                if (set_ev) begin
                    if (is_alarm) begin
                        state_d = S_LOAD_A;
                        alm_h_d = edit_h_q;
                        alm_m_d = edit_m_q;
                    end else begin
                        state_d = S_LOAD_T;
                    end
                end else if (mode_ev) begin
                    case (state_q)
                        S_T_HOUR: state_d = S_T_MIN;
                        S_T_MIN: begin
                            state_d  = S_A_HOUR;
                            edit_h_d = alm_h_q;
                            edit_m_d = alm_m_q;
                        end
                        S_A_HOUR: state_d = S_A_MIN;
                        default:  state_d = S_IDLE;
                    endcase
                end else if (inc_ev) begin
                    if (is_hour) begin
                        edit_h_d = hour_inc(edit_h_q);
                    end else begin
                        edit_m_d = min_inc(edit_m_q);
                    end
                end else if (to_expire) begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD_T, S_LOAD_A: begin
                if (ld_cnt_q == LD_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_q     <= '0;
            db_cnt_q  <= '0;
            press_q   <= '0;
            rep_cnt_q <= '0;
            rep_q     <= 1'b0;
            to_cnt_q  <= '0;
            ld_cnt_q  <= '0;
            state_q   <= S_IDLE;
            edit_h_q  <= '0;
            edit_m_q  <= '0;
            alm_h_q   <= '0;
            alm_m_q   <= '0;
            al_on_q   <= 1'b0;
        end else begin
            deb_q     <= deb_d;
            db_cnt_q  <= db_cnt_d;
            press_q   <= press_d;
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
            to_cnt_q  <= to_cnt_d;
            ld_cnt_q  <= ld_cnt_d;
            state_q   <= state_d;
            edit_h_q  <= edit_h_d;
            edit_m_q  <= edit_m_d;
            alm_h_q   <= alm_h_d;
            alm_m_q   <= alm_m_d;
            al_on_q   <= al_on_d;
        end
    end

    // Output decode from registered state; load strobes exist only in the load states
    always_comb begin
        H_in1      = edit_h_q[5:4];
        H_in0      = edit_h_q[3:0];
        M_in1      = edit_m_q[7:4];
        M_in0      = edit_m_q[3:0];
        AL_ON      = al_on_q;
        LD_time    = (state_q == S_LOAD_T);
        LD_alarm   = (state_q == S_LOAD_A);
        edit_sel   = 2'd0;
        edit_alarm = 1'b0;
        case (state_q)
            S_T_HOUR: edit_sel = 2'd1;
            S_T_MIN:  edit_sel = 2'd2;
            S_A_HOUR: begin
                edit_sel   = 2'd1;
                edit_alarm = 1'b1;
            end
            S_A_MIN: begin
                edit_sel   = 2'd2;
                edit_alarm = 1'b1;
            end
            default: edit_sel = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: directed scenarios plus randomized button
// activity, compared every cycle against a behavioural model of the clock
// setting rules (times kept as integers, phases instead of states).
module tb_time_set_ctrl;

    localparam int DB = 2;
    localparam int RP = 5;
    localparam int TO = 300;
    localparam int LH = 10;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       btn_mode, btn_inc, btn_set;
    logic [1:0] cur_H1;
    logic [3:0] cur_H0, cur_M1, cur_M0;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0;
    logic       LD_time, LD_alarm, AL_ON, edit_alarm;
    logic [1:0] edit_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    time_set_ctrl #(
        .DEBOUNCE_TICKS(DB),
        .REPEAT_TICKS  (RP),
        .TIMEOUT_TICKS (TO),
        .LOAD_HOLD     (LH)
    ) dut (
        .clk       (clk),
        .reset     (rst_b),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .btn_set   (btn_set),
        .cur_H1    (cur_H1),
        .cur_H0    (cur_H0),
        .cur_M1    (cur_M1),
        .cur_M0    (cur_M0),
        .H_in1     (H_in1),
        .H_in0     (H_in0),
        .M_in1     (M_in1),
        .M_in0     (M_in0),
        .LD_time   (LD_time),
        .LD_alarm  (LD_alarm),
        .AL_ON     (AL_ON),
        .edit_sel  (edit_sel),
        .edit_alarm(edit_alarm)
    );

    // Model: button index 0=mode 1=inc 2=set; phase 0=idle 1=editing 2=loading
    int d1[3], d2[3], lvl[3], dbrun[3];
    bit prs[3];
    bit rep;
    int runr, quiet;
    int phase, fld, load_left;
    bit alm, ld_alarm_sel, al;
    int eh1, eh0, em1, em0, ah1, ah0, am1, am0;

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            d1[b] = 0; d2[b] = 0; lvl[b] = 0; dbrun[b] = 0; prs[b] = 0;
        end
        rep = 0; runr = 0; quiet = 0;
        phase = 0; fld = 0; load_left = 0; alm = 0; ld_alarm_sel = 0; al = 0;
        eh1 = 0; eh0 = 0; em1 = 0; em0 = 0;
        ah1 = 0; ah0 = 0; am1 = 0; am0 = 0;
    endtask

    task automatic hour_step();
        int v;
        bit ok;
        ok = (eh1 <= 2) && (eh0 <= 9) && (eh1 * 10 + eh0 <= 23);
        v  = ok ? (eh1 * 10 + eh0 + 1) % 24 : 0;
        eh1 = v / 10;
        eh0 = v % 10;
    endtask

    task automatic min_step();
        int v;
        bit ok;
        ok = (em1 <= 5) && (em0 <= 9);
        v  = ok ? (em1 * 10 + em0 + 1) % 60 : 0;
        em1 = v / 10;
        em0 = v % 10;
    endtask

    // One clock edge of the model, using the values present just before the edge
    task automatic model_edge();
        int raw[3];
        bit s, m, i, ed, any, tmo, rep_n;
        int x;
        if (!rst_b) begin
            model_reset();
            return;
        end
        raw[0] = int'(btn_mode); raw[1] = int'(btn_inc); raw[2] = int'(btn_set);
        s   = prs[2];
        m   = prs[0];
        i   = prs[1] | rep;
        ed  = (phase == 1);
        any = s | m | i;
        tmo = ed && !any && (quiet == TO - 1);
        if (lvl[1] == 1 && ed) begin
            runr++;
            rep_n = (runr % RP == 0);
        end else begin
            runr  = 0;
            rep_n = 0;
        end
        quiet = (ed && !any) ? quiet + 1 : 0;
        case (phase)
            0: begin
                if (s) al = !al;
                else if (m) begin
                    phase = 1; alm = 0; fld = 1;
                    eh1 = int'(cur_H1); eh0 = int'(cur_H0);
                    em1 = int'(cur_M1); em0 = int'(cur_M0);
                end
            end
            1: begin
                if (s) begin
                    phase = 2; load_left = LH; ld_alarm_sel = alm;
                    if (alm) begin
                        ah1 = eh1; ah0 = eh0; am1 = em1; am0 = em0;
                    end
                end else if (m) begin
                    if (fld == 1) fld = 2;
                    else if (!alm) begin
                        alm = 1; fld = 1;
                        eh1 = ah1; eh0 = ah0; em1 = am1; em0 = am0;
                    end else phase = 0;
                end else if (i) begin
                    if (fld == 1) hour_step();
                    else min_step();
                end else if (tmo) phase = 0;
            end
            default: begin
                load_left--;
                if (load_left == 0) phase = 0;
            end
        endcase
        rep = rep_n;
        for (int b = 0; b < 3; b++) begin
            x = d2[b];
            d2[b] = d1[b];
            d1[b] = raw[b];
            prs[b] = 0;
            if (x == lvl[b]) dbrun[b] = 0;
            else begin
                dbrun[b]++;
                if (dbrun[b] == DB) begin
                    lvl[b] = x; dbrun[b] = 0; prs[b] = (x == 1);
                end
            end
        end
    endtask

    function automatic logic [19:0] model_vec();
        logic [1:0] sel;
        sel = (phase == 1) ? 2'(fld) : 2'd0;
        return {2'(eh1), 4'(eh0), 4'(em1), 4'(em0),
                (phase == 2) && !ld_alarm_sel, (phase == 2) && ld_alarm_sel,
                al, sel, (phase == 1) && alm};
    endfunction

    function automatic logic [19:0] dut_vec();
        return {H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm, AL_ON, edit_sel, edit_alarm};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("outputs", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic set_btn(input int b, input logic v);
        case (b)
            0:       btn_mode = v;
            1:       btn_inc  = v;
            default: btn_set  = v;
        endcase
    endtask

    task automatic press(input int b);
        set_btn(b, 1'b1);
        repeat (3) cyc();
        set_btn(b, 1'b0);
        repeat (6) cyc();
    endtask

    task automatic set_cur(input int h, input int m);
        cur_H1 = 2'(h / 10); cur_H0 = 4'(h % 10);
        cur_M1 = 4'(m / 10); cur_M0 = 4'(m % 10);
    endtask

    // Press set and count the cycles each load strobe is seen high
    task automatic load_window(output int nt, output int na);
        nt = 0; na = 0;
        set_btn(2, 1'b1);
        for (int k = 0; k < 30; k++) begin
            if (k == 3) set_btn(2, 1'b0);
            cyc();
            if (LD_time)  nt++;
            if (LD_alarm) na++;
        end
    endtask

    // Asynchronous reset asserted mid-cycle, held across one edge, released at a negedge
    task automatic reset_mid();
        @(posedge clk);
        model_edge();
        #3;
        rst_b = 1'b0;
        model_reset();
        #1;
        chk("reset_async_zero", 32'(dut_vec()), 32'd0);
        @(negedge clk);
        chk("outputs", 32'(dut_vec()), 32'(model_vec()));
        cyc();
        rst_b = 1'b1;
        cyc();
    endtask

    initial begin
        int nt, na, n;
        int left[3];
        bit lv[3];
        rst_b = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_set = 1'b0;
        set_cur(12, 34);
        model_reset();
        @(negedge clk);
        chk("reset_state", 32'(dut_vec()), 32'd0);
        cyc();
        rst_b = 1'b1;
        repeat (3) cyc();

        // alarm enable toggles in idle, then time edit seeded from the clock
        press(2);
        chk("al_on_set", 32'(AL_ON), 32'd1);
        press(2);
        chk("al_on_clear", 32'(AL_ON), 32'd0);
        press(0);
        chk("t1_edit_sel", 32'(edit_sel), 32'd1);
        chk("t1_seed", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h1234);
        chk("t1_model_hour", 32'(eh1 * 10 + eh0), 32'd12);
        load_window(nt, na);
        chk("t1_ld_time_len", 32'(nt), 32'd10);
        chk("t1_ld_alarm_len", 32'(na), 32'd0);
        chk("t1_back_idle", 32'(edit_sel), 32'd0);

        // hour and minute wrap
        set_cur(22, 58);
        press(0);
        chk("t2_seed", 32'({H_in1, H_in0}), 32'h22);
        press(1);
        chk("t2_hour_23", 32'({H_in1, H_in0}), 32'h23);
        press(1);
        chk("t2_hour_00", 32'({H_in1, H_in0}), 32'h00);
        press(0);
        chk("t2_min_sel", 32'(edit_sel), 32'd2);
        press(1);
        chk("t2_min_59", 32'({M_in1, M_in0}), 32'h59);
        press(1);
        chk("t2_min_00", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h0000);
        load_window(nt, na);
        chk("t2_ld_time_len", 32'(nt), 32'd10);

        // held inc: one step on the press and one per repeat period
        set_cur(10, 0);
        press(0);
        press(0);
        set_btn(1, 1'b1);
        repeat (20) cyc();
        set_btn(1, 1'b0);
        repeat (8) cyc();
        chk("t3_repeat_count", 32'({M_in1, M_in0}), 32'h05);
        chk("t3_model_min", 32'(em1 * 10 + em0), 32'd5);
        chk("t3_hour_kept", 32'({H_in1, H_in0}), 32'h10);
        repeat (3) press(0);
        chk("t3_idle", 32'(edit_sel), 32'd0);

        // alarm edit and reload from shadow
        repeat (3) press(0);
        chk("t4_alarm_flag", 32'({edit_sel, edit_alarm}), 32'b011);
        chk("t4_shadow_reset", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h0000);
        repeat (6) press(1);
        press(0);
        repeat (30) press(1);
        chk("t4_edit_0630", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h0630);
        load_window(nt, na);
        chk("t4_ld_alarm_len", 32'(na), 32'd10);
        chk("t4_ld_time_len", 32'(nt), 32'd0);
        repeat (3) press(0);
        chk("t4_shadow_0630", 32'({H_in1, H_in0, M_in1, M_in0}), 32'h0630);
        chk("t4_model_shadow", 32'(ah1 * 1000 + ah0 * 100 + am1 * 10 + am0), 32'd630);
        repeat (2) press(0);

        // one-cycle glitch rejected; mode+set together resolves to set
        set_btn(0, 1'b1);
        cyc();
        set_btn(0, 1'b0);
        repeat (8) cyc();
        chk("t5_glitch", 32'(edit_sel), 32'd0);
        set_cur(1, 2);
        press(0);
        press(0);
        chk("t5_in_tmin", 32'(edit_sel), 32'd2);
        btn_mode = 1'b1; btn_set = 1'b1;
        repeat (3) cyc();
        btn_mode = 1'b0; btn_set = 1'b0;
        repeat (3) cyc();
        chk("t5_set_wins", 32'({LD_time, edit_sel}), 32'b100);
        repeat (12) cyc();

        // timeout in A_MIN without load, edit regs retained
        repeat (4) press(0);
        chk("t6_in_amin", 32'({edit_sel, edit_alarm}), 32'b101);
        n = 0;
        repeat (290) begin
            cyc();
            if (LD_time || LD_alarm) n++;
        end
        chk("t6_not_early", 32'(edit_sel), 32'd2);
        repeat (10) begin
            cyc();
            if (LD_time || LD_alarm) n++;
        end
        chk("t6_timeout", 32'(edit_sel), 32'd0);
        chk("t6_no_load", 32'(n), 32'd0);
        chk("t6_regs_kept", 32'({M_in1, M_in0}), 32'h30);

        // reset during LOAD_T cycle 4
        press(2);
        set_cur(12, 34);
        press(0);
        set_btn(2, 1'b1);
        repeat (3) cyc();
        set_btn(2, 1'b0);
        repeat (4) cyc();
        chk("t6_ld_before_reset", 32'({LD_time, AL_ON}), 32'b11);
        reset_mid();
        n = 0;
        repeat (15) begin
            cyc();
            if (LD_time || LD_alarm) n++;
        end
        chk("t6_no_reissue", 32'(n), 32'd0);

        // randomized button activity against the model
        for (int b = 0; b < 3; b++) begin
            left[b] = 0;
            lv[b]   = 0;
        end
        for (int c = 0; c < 4000; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (left[b] == 0) begin
                    lv[b] = !lv[b];
                    if (lv[b]) left[b] = (b == 1) ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 6));
                    else if (b == 0) left[b] = int'($urandom_range(10, 90));
                    else if (b == 1) left[b] = int'($urandom_range(3, 30));
                    else left[b] = int'($urandom_range(30, 200));
                    set_btn(b, lv[b]);
                end
                left[b]--;
            end
            if (c % 40 == 0) begin
                if ($urandom_range(0, 3) == 0) begin
                    cur_H1 = 2'($urandom_range(0, 3));
                    cur_H0 = 4'($urandom_range(0, 15));
                    cur_M1 = 4'($urandom_range(0, 15));
                    cur_M0 = 4'($urandom_range(0, 15));
                end else begin
                    set_cur(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
                end
            end
            if ($urandom_range(0, 1499) == 0) reset_mid();
            else cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
